// File: rtl/jstk_nav_pkg.sv
// rtl/jstk_nav_pkg.sv - shared types and helpers for the joystick navigator
// Purpose: centre constant, direction / FSM / axis-state enums and the
//          direction-to-one-hot decode used for dir_held and the pulse register.
// Ports:   none (package).
package jstk_nav_pkg;

  localparam logic [9:0] CENTER = 10'd512;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    UP    = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    RIGHT = 3'd4
  } dir_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    REPEAT = 2'd2
  } fsm_e;

  typedef enum logic [1:0] {
    CTR = 2'd0,
    LO  = 2'd1,
    HI  = 2'd2
  } axis_e;

  // Bit order {up, down, left, right}.
  function automatic logic [3:0] dir_onehot(input dir_e d);
    case (d)
      UP:      return 4'b1000;
      DOWN:    return 4'b0100;
      LEFT:    return 4'b0010;
      RIGHT:   return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/jstk_axis_cls.sv
// rtl/jstk_axis_cls.sv - per-axis dead-zone / hysteresis classifier
// Purpose: holds the axis hysteresis state, updated on i_valid, and reports the
//          post-sample state plus |sample-512|.
// Ports:   i_clk, i_rst_n (async active-low), i_valid (sample strobe),
//          i_clear (link-loss clear), i_sample[9:0],
//          o_state (state after this sample; register value when not valid),
//          o_mag[9:0] (distance of i_sample from centre).
module jstk_axis_cls
  import jstk_nav_pkg::*;
#(
  parameter logic [9:0] LO_TH = 10'd256,
  parameter logic [9:0] HI_TH = 10'd768,
  parameter logic [9:0] HYST  = 10'd32
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic       i_clear,
  input  logic [9:0] i_sample,
  output axis_e      o_state,
  output logic [9:0] o_mag
);

  axis_e       r_state;
  axis_e       w_raw;
  logic [10:0] w_s11;
  logic [10:0] w_lo_rel;
  logic [10:0] w_hi_rel;

  // Release points carried at 11 bits so the margin sum cannot wrap.
  assign w_s11    = {1'b0, i_sample};
  assign w_lo_rel = {1'b0, LO_TH} + {1'b0, HYST};
  assign w_hi_rel = {1'b0, HI_TH} - {1'b0, HYST};

  assign o_mag = (i_sample >= CENTER) ? (i_sample - CENTER) : (CENTER - i_sample);

  always_comb begin
    w_raw = CTR;
    if (i_sample < LO_TH) begin
      w_raw = LO;
    end else if (i_sample > HI_TH) begin
      w_raw = HI;
    end
  end

  // Once deflected, the axis only leaves that side past the release margin;
  // after release the plain threshold result applies (can jump straight across).
  always_comb begin
    o_state = r_state;
    if (i_valid) begin
      case (r_state)
        LO:      if (w_s11 >= w_lo_rel) o_state = w_raw;
        HI:      if (w_s11 <= w_hi_rel) o_state = w_raw;
        default: o_state = w_raw;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= CTR;
    end else if (i_clear) begin
      r_state <= CTR;
    end else begin
      r_state <= o_state;
    end
  end

endmodule

// File: rtl/jstk_nav.sv
// rtl/jstk_nav.sv - joystick sample to navigation pulse converter
// Purpose: turns qualified X/Y samples and button levels into one-cycle
//          direction pulses (dead-zone, hysteresis, dominant axis, optional
//          auto-repeat), debounced press pulses and a link-alive flag.
//          Auto-repeat is built only when JSTK_NAV_REPEAT_EN is defined.
// Ports:   clk, rst (async active-low), jstk_x/jstk_y[9:0], btn_jstk,
//          btn_trigger, data_valid (sample strobe);
//          dir_up/down/left/right (pulses), dir_held[3:0] {up,down,left,right},
//          press_jstk, press_trigger (pulses), link_ok.
module jstk_nav
  import jstk_nav_pkg::*;
#(
  parameter logic [9:0]  LO_TH        = 10'd256,
  parameter logic [9:0]  HI_TH        = 10'd768,
  parameter logic [9:0]  HYST         = 10'd32,
  parameter logic [23:0] REPEAT_DELAY = 24'd5_000_000,
  parameter logic [23:0] REPEAT_RATE  = 24'd1_500_000,
  parameter logic [23:0] TIMEOUT      = 24'd10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] jstk_x,
  input  logic [9:0] jstk_y,
  input  logic       btn_jstk,
  input  logic       btn_trigger,
  input  logic       data_valid,
  output logic       dir_up,
  output logic       dir_down,
  output logic       dir_left,
  output logic       dir_right,
  output logic [3:0] dir_held,
  output logic       press_jstk,
  output logic       press_trigger,
  output logic       link_ok
);

  axis_e       w_x_st, w_y_st;
  logic [9:0]  w_x_mag, w_y_mag;
  dir_e        w_x_dir, w_y_dir, w_cand;
  logic        w_expire;
  logic [23:0] r_idle_cnt;
  logic        r_link_ok;
  fsm_e        r_state, w_state_nxt;
  dir_e        r_dir, w_dir_nxt, w_pulse_dir;
  logic [3:0]  r_pulse;
  logic [1:0]  w_btn, r_btn_last, r_btn_deb, w_deb_nxt, r_press;
`ifdef JSTK_NAV_REPEAT_EN
  logic [23:0] r_timer, w_timer_nxt;
`else
  logic        w_unused_rpt;
  assign w_unused_rpt = ^{REPEAT_DELAY, REPEAT_RATE};
`endif

  jstk_axis_cls #(.LO_TH(LO_TH), .HI_TH(HI_TH), .HYST(HYST)) u_axis_x (
    .i_clk(clk), .i_rst_n(rst), .i_valid(data_valid), .i_clear(w_expire),
    .i_sample(jstk_x), .o_state(w_x_st), .o_mag(w_x_mag)
  );

  jstk_axis_cls #(.LO_TH(LO_TH), .HI_TH(HI_TH), .HYST(HYST)) u_axis_y (
    .i_clk(clk), .i_rst_n(rst), .i_valid(data_valid), .i_clear(w_expire),
    .i_sample(jstk_y), .o_state(w_y_st), .o_mag(w_y_mag)
  );

  // Candidate: larger deflection wins, X wins ties.
  always_comb begin
    w_x_dir = NONE;
    w_y_dir = NONE;
    w_cand  = NONE;
    if (w_x_st == LO) w_x_dir = LEFT;
    if (w_x_st == HI) w_x_dir = RIGHT;
    if (w_y_st == LO) w_y_dir = DOWN;
    if (w_y_st == HI) w_y_dir = UP;
    if (w_x_dir != NONE && (w_y_dir == NONE || w_x_mag >= w_y_mag)) begin
      w_cand = w_x_dir;
    end else if (w_y_dir != NONE) begin
      w_cand = w_y_dir;
    end
  end

  // Expiry fires on the edge where the idle count reaches TIMEOUT.
  assign w_expire = !data_valid && (r_idle_cnt == TIMEOUT - 24'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idle_cnt <= '0;
      r_link_ok  <= 1'b0;
    end else if (data_valid) begin
      r_idle_cnt <= '0;
      r_link_ok  <= 1'b1;
    end else begin
      if (r_idle_cnt != TIMEOUT) r_idle_cnt <= r_idle_cnt + 24'd1;
      if (w_expire) r_link_ok <= 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_pulse_dir = NONE;
`ifdef JSTK_NAV_REPEAT_EN
    w_timer_nxt = r_timer;
`endif
    if (w_expire || (data_valid && w_cand == NONE)) begin
      w_state_nxt = IDLE;
      w_dir_nxt   = NONE;
`ifdef JSTK_NAV_REPEAT_EN
      w_timer_nxt = '0;
`endif
    end else if (data_valid && (r_state == IDLE || w_cand != r_dir)) begin
      // New deflection or direction change; overrides any repeat due now.
      w_state_nxt = FIRST;
      w_dir_nxt   = w_cand;
      w_pulse_dir = w_cand;
`ifdef JSTK_NAV_REPEAT_EN
      w_timer_nxt = 24'd1;
`endif
    end
`ifdef JSTK_NAV_REPEAT_EN
    else begin
      // Timer is loaded with 1 on each pulse, so a compare against the
      // period places the next pulse exactly that many cycles later.
      case (r_state)
        FIRST: begin
          if (r_timer == REPEAT_DELAY) begin
            w_pulse_dir = r_dir;
            w_timer_nxt = 24'd1;
            w_state_nxt = REPEAT;
          end else begin
            w_timer_nxt = r_timer + 24'd1;
          end
        end
        REPEAT: begin
          if (r_timer == REPEAT_RATE) begin
            w_pulse_dir = r_dir;
            w_timer_nxt = 24'd1;
          end else begin
            w_timer_nxt = r_timer + 24'd1;
          end
        end
        default: ;
      endcase
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_dir   <= NONE;
      r_pulse <= '0;
`ifdef JSTK_NAV_REPEAT_EN
      r_timer <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_dir   <= w_dir_nxt;
      r_pulse <= dir_onehot(w_pulse_dir);
`ifdef JSTK_NAV_REPEAT_EN
      r_timer <= w_timer_nxt;
`endif
    end
  end

  // Bit 0 jstk, bit 1 trigger. Two equal samples set the state, else hold.
  assign w_btn     = {btn_trigger, btn_jstk};
  assign w_deb_nxt = (w_btn & r_btn_last) | (r_btn_deb & (w_btn ^ r_btn_last));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_btn_last <= '0;
      r_btn_deb  <= '0;
      r_press    <= '0;
    end else if (w_expire) begin
      r_btn_last <= '0;
      r_btn_deb  <= '0;
      r_press    <= '0;
    end else if (data_valid) begin
      r_btn_last <= w_btn;
      r_btn_deb  <= w_deb_nxt;
      r_press    <= w_deb_nxt & ~r_btn_deb;
    end else begin
      r_press    <= '0;
    end
  end

  assign {dir_up, dir_down, dir_left, dir_right} = r_pulse;
  assign dir_held      = dir_onehot(r_dir);
  assign press_jstk    = r_press[0];
  assign press_trigger = r_press[1];
  assign link_ok       = r_link_ok;

endmodule

// File: tb/tb_jstk_nav.sv
// tb/tb_jstk_nav.sv - directed self-checking bench for jstk_nav
module tb_jstk_nav;

`ifdef JSTK_NAV_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [9:0] jstk_x, jstk_y;
  logic       btn_jstk, btn_trigger, data_valid;
  logic       dir_up, dir_down, dir_left, dir_right;
  logic [3:0] dir_held;
  logic       press_jstk, press_trigger, link_ok;
  logic [3:0] w_pulses;

  int n_checks = 0;
  int n_pass   = 0;

  assign w_pulses = {dir_up, dir_down, dir_left, dir_right};

  jstk_nav #(
    .REPEAT_DELAY(24'd20),
    .REPEAT_RATE (24'd5),
    .TIMEOUT     (24'd100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .jstk_x       (jstk_x),
    .jstk_y       (jstk_y),
    .btn_jstk     (btn_jstk),
    .btn_trigger  (btn_trigger),
    .data_valid   (data_valid),
    .dir_up       (dir_up),
    .dir_down     (dir_down),
    .dir_left     (dir_left),
    .dir_right    (dir_right),
    .dir_held     (dir_held),
    .press_jstk   (press_jstk),
    .press_trigger(press_trigger),
    .link_ok      (link_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive at a negedge, let one active edge pass, return at the next negedge.
  task automatic cyc(input bit dv, input logic [9:0] x, input logic [9:0] y,
                     input bit bj, input bit bt);
    data_valid  = dv;
    jstk_x      = x;
    jstk_y      = y;
    btn_jstk    = bj;
    btn_trigger = bt;
    @(posedge clk);
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({w_pulses, dir_held, press_jstk, press_trigger, link_ok} !== 11'd0)
      $display("FAIL reset_outputs got=%b want=0", {w_pulses, dir_held, press_jstk, press_trigger, link_ok});
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_repeat();
    logic [3:0] exp_p;
    for (int c = 0; c < 60; c++) begin
      cyc(c % 10 == 0, 10'd100, 10'd512, 1'b0, 1'b0);
      exp_p = (c == 0 || (REP && c >= 20 && ((c - 20) % 5) == 0)) ? 4'b0010 : 4'b0000;
      n_checks++;
      if (w_pulses !== exp_p || dir_held !== 4'b0010)
        $display("FAIL repeat_left c=%0d pulses=%b held=%b want pulses=%b held=0010", c, w_pulses, dir_held, exp_p);
      else n_pass++;
    end
    for (int c = 0; c < 20; c++) begin
      cyc(c % 10 == 0, 10'd512, 10'd512, 1'b0, 1'b0);
      n_checks++;
      if (w_pulses !== 4'b0000 || dir_held !== 4'b0000)
        $display("FAIL repeat_release c=%0d pulses=%b held=%b want 0000/0000", c, w_pulses, dir_held);
      else n_pass++;
    end
  endtask

  task automatic test_dominant();
    logic [3:0] exp_p;
    cyc(1'b1, 10'd900, 10'd1000, 1'b0, 1'b0);
    n_checks++;
    if (w_pulses !== 4'b1000 || dir_held !== 4'b1000)
      $display("FAIL dominant_up pulses=%b held=%b want 1000/1000", w_pulses, dir_held);
    else n_pass++;
    for (int c = 1; c < 10; c++) begin
      cyc(1'b0, 10'd900, 10'd1000, 1'b0, 1'b0);
      n_checks++;
      if (w_pulses !== 4'b0000)
        $display("FAIL dominant_up_quiet c=%0d pulses=%b want 0000", c, w_pulses);
      else n_pass++;
    end
    cyc(1'b1, 10'd1000, 10'd900, 1'b0, 1'b0);
    n_checks++;
    if (w_pulses !== 4'b0001 || dir_held !== 4'b0001)
      $display("FAIL dominant_switch pulses=%b held=%b want 0001/0001", w_pulses, dir_held);
    else n_pass++;
    for (int c = 1; c < 25; c++) begin
      cyc(c % 10 == 0, 10'd1000, 10'd900, 1'b0, 1'b0);
      exp_p = (REP && c == 20) ? 4'b0001 : 4'b0000;
      n_checks++;
      if (w_pulses !== exp_p || dir_held !== 4'b0001)
        $display("FAIL dominant_restart c=%0d pulses=%b held=%b want %b/0001", c, w_pulses, dir_held, exp_p);
      else n_pass++;
    end
    cyc(1'b1, 10'd512, 10'd512, 1'b0, 1'b0);
    cyc(1'b1, 10'd100, 10'd924, 1'b0, 1'b0);
    n_checks++;
    if (w_pulses !== 4'b0010 || dir_held !== 4'b0010)
      $display("FAIL dominant_tie pulses=%b held=%b want 0010/0010", w_pulses, dir_held);
    else n_pass++;
    cyc(1'b1, 10'd512, 10'd512, 1'b0, 1'b0);
    n_checks++;
    if (dir_held !== 4'b0000)
      $display("FAIL dominant_clear held=%b want 0000", dir_held);
    else n_pass++;
  endtask

  task automatic test_hysteresis();
    logic [9:0] xs [10];
    logic [9:0] ys [10];
    logic [3:0] ep [10];
    logic [3:0] eh [10];
    xs = '{10'd250, 10'd280, 10'd287, 10'd288, 10'd256, 10'd769, 10'd737, 10'd736, 10'd768, 10'd512};
    ys = '{10'd512, 10'd512, 10'd512, 10'd512, 10'd512, 10'd512, 10'd512, 10'd512, 10'd512, 10'd200};
    ep = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
    eh = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0100};
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, xs[i], ys[i], 1'b0, 1'b0);
      n_checks++;
      if (w_pulses !== ep[i] || dir_held !== eh[i])
        $display("FAIL hyst step=%0d x=%0d y=%0d pulses=%b held=%b want %b/%b", i, xs[i], ys[i], w_pulses, dir_held, ep[i], eh[i]);
      else n_pass++;
    end
    cyc(1'b1, 10'd512, 10'd512, 1'b0, 1'b0);
  endtask

  task automatic test_buttons();
    logic [5:0] bt_seq;
    logic [5:0] bj_seq;
    bt_seq = 6'b111010;
    bj_seq = 6'b010101;
    for (int s = 0; s < 6; s++) begin
      for (int c = 0; c < 10; c++) begin
        cyc(c == 0, 10'd512, 10'd512, bj_seq[s], bt_seq[s]);
        n_checks++;
        if (press_trigger !== (s == 4 && c == 0) || press_jstk !== 1'b0 || w_pulses !== 4'b0000)
          $display("FAIL buttons s=%0d c=%0d trig=%b jstk=%b pulses=%b want trig=%b jstk=0", s, c, press_trigger, press_jstk, w_pulses, (s == 4 && c == 0));
        else n_pass++;
      end
    end
  endtask

  task automatic test_link();
    logic [3:0] exp_p;
    cyc(1'b1, 10'd900, 10'd512, 1'b1, 1'b0);
    n_checks++;
    if (w_pulses !== 4'b0001 || dir_held !== 4'b0001 || link_ok !== 1'b1 || press_jstk !== 1'b0)
      $display("FAIL link_start pulses=%b held=%b link=%b press=%b want 0001/0001/1/0", w_pulses, dir_held, link_ok, press_jstk);
    else n_pass++;
    cyc(1'b1, 10'd900, 10'd512, 1'b1, 1'b0);
    n_checks++;
    if (press_jstk !== 1'b1 || w_pulses !== 4'b0000)
      $display("FAIL link_press press=%b pulses=%b want 1/0000", press_jstk, w_pulses);
    else n_pass++;
    for (int c = 1; c <= 110; c++) begin
      cyc(1'b0, 10'd900, 10'd512, 1'b1, 1'b0);
      exp_p = (REP && c >= 19 && c <= 99 && ((c - 19) % 5) == 0) ? 4'b0001 : 4'b0000;
      n_checks++;
      if (link_ok !== (c < 100) || w_pulses !== exp_p || dir_held !== ((c < 100) ? 4'b0001 : 4'b0000) || press_jstk !== 1'b0)
        $display("FAIL link_silence c=%0d link=%b pulses=%b held=%b press=%b want link=%b pulses=%b", c, link_ok, w_pulses, dir_held, press_jstk, (c < 100), exp_p);
      else n_pass++;
    end
    cyc(1'b1, 10'd900, 10'd512, 1'b1, 1'b0);
    n_checks++;
    if (link_ok !== 1'b1 || w_pulses !== 4'b0001 || dir_held !== 4'b0001 || press_jstk !== 1'b0)
      $display("FAIL link_resume link=%b pulses=%b held=%b press=%b want 1/0001/0001/0", link_ok, w_pulses, dir_held, press_jstk);
    else n_pass++;
    cyc(1'b1, 10'd900, 10'd512, 1'b1, 1'b0);
    n_checks++;
    if (press_jstk !== 1'b1 || w_pulses !== 4'b0000)
      $display("FAIL link_repress press=%b pulses=%b want 1/0000", press_jstk, w_pulses);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c <= 20; c++) cyc(c % 10 == 0, 10'd100, 10'd512, 1'b0, 1'b0);
    n_checks++;
    if (dir_held !== 4'b0010 || w_pulses !== (REP ? 4'b0010 : 4'b0000))
      $display("FAIL midreset_pre held=%b pulses=%b want 0010/%b", dir_held, w_pulses, (REP ? 4'b0010 : 4'b0000));
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({w_pulses, dir_held, press_jstk, press_trigger, link_ok} !== 11'd0)
      $display("FAIL midreset_async got=%b want=0", {w_pulses, dir_held, press_jstk, press_trigger, link_ok});
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 30; c++) begin
      cyc(1'b0, 10'd512, 10'd512, 1'b0, 1'b0);
      n_checks++;
      if (w_pulses !== 4'b0000 || dir_held !== 4'b0000)
        $display("FAIL midreset_quiet c=%0d pulses=%b held=%b want 0000/0000", c, w_pulses, dir_held);
      else n_pass++;
    end
    cyc(1'b1, 10'd512, 10'd512, 1'b0, 1'b0);
    n_checks++;
    if (w_pulses !== 4'b0000 || dir_held !== 4'b0000 || link_ok !== 1'b1)
      $display("FAIL midreset_centre pulses=%b held=%b link=%b want 0000/0000/1", w_pulses, dir_held, link_ok);
    else n_pass++;
  endtask

  initial begin
    jstk_x      = 10'd512;
    jstk_y      = 10'd512;
    btn_jstk    = 1'b0;
    btn_trigger = 1'b0;
    data_valid  = 1'b0;
    test_reset();
    test_repeat();
    test_dominant();
    test_hysteresis();
    test_buttons();
    test_link();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
